// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory
// and fills the IF/ID pipeline register, with stall/flush, branch/jump
// redirects and misaligned-target trapping.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [31:0] bad_vaddr
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] next_pc_c;
  logic            redirect_c;
  logic            misaligned_c;

  assign imem_addr  = pc;
  assign pc_plus4_c = pc + XLEN'(4);

  // Redirect target selection (branch beats jump) and alignment check.
  always_comb begin
    redirect_c   = branch_taken | jump;
    target_c     = branch_taken ? branch_target : jump_target;
    misaligned_c = redirect_c && (target_c[1:0] != 2'b00);
    next_pc_c    = pc_plus4_c;
    if (redirect_c) begin
      next_pc_c = misaligned_c ? EXC_VECTOR : target_c;
    end else if (stall) begin
      next_pc_c = pc;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc_c;
    end
  end

  // IF/ID register: a redirect squashes the word fetched in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (flush || redirect_c) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= pc_plus4_c;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if_id_instr <= imem_data;
      if_id_pc4   <= pc_plus4_c;
      if_id_valid <= 1'b1;
    end
  end

  // Misaligned-redirect pulse and sticky faulting address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
      bad_vaddr    <= '0;
    end else begin
      misalign_err <= misaligned_c;
      if (misaligned_c) begin
        bad_vaddr <= target_c;
      end
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline. Owns the program counter, drives the address of the combinational instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register for the decode stage. Handles hazard-unit stalls and flushes, branch and jump redirects, and misaligned-target traps.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `EXC_VECTOR`, 32'h0000_0080, PC loaded when a redirect target is misaligned.
- `NOP_INSTR`, 32'h0000_0000 (sll $0,$0,0), word inserted into IF/ID on a bubble.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `stall`  input  1  hold PC and IF/ID contents.
- `flush`  input  1  replace the next IF/ID contents with a bubble.
- `branch_taken`  input  1  redirect to `branch_target`.
- `branch_target`  input  32  byte address.
- `jump`  input  1  redirect to `jump_target`.
- `jump_target`  input  32  byte address.
- `imem_addr`  output  32  byte address to instruction memory; equals the PC register.
- `imem_data`  input  32  instruction word, combinational from `imem_addr`.
- `if_id_instr`  output  32  registered instruction.
- `if_id_pc4`  output  32  registered PC+4 of that instruction.
- `if_id_valid`  output  1  1 = real instruction, 0 = bubble.
- `misalign_err`  output  1  one-cycle registered pulse on a misaligned redirect.
- `bad_vaddr`  output  32  offending target, held until the next misaligned redirect or reset.

## Operation
- `pc` is a 32-bit register. `imem_addr = pc`, with no added logic.
- Next-PC selection, highest priority first:
  - `branch_taken`: next PC is `branch_target`.
  - `jump`: next PC is `jump_target`.
  - `stall`: next PC is `pc`.
  - otherwise: next PC is `pc + 4`.
- Redirects win over `stall`. Branch wins over jump when both are asserted.
- Misaligned redirect: the selected target has bits [1:0] != 2'b00.
  - PC loads `EXC_VECTOR` instead of the target.
  - `bad_vaddr` loads the target.
  - `misalign_err` is 1 for exactly the next cycle.
  - The IF/ID register takes a bubble.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000. Bits [1:0] of the PC are always 00.
- IF/ID update, highest priority first:
  - `flush`, any taken redirect, or a misaligned redirect: bubble (`if_id_instr` = `NOP_INSTR`, `if_id_valid` = 0, `if_id_pc4` = `pc + 4`).
  - `stall`: hold all three fields.
  - otherwise: `if_id_instr` = `imem_data`, `if_id_pc4` = `pc + 4`, `if_id_valid` = 1.
- A redirect always squashes the word fetched in the same cycle. This gives a single-cycle taken-branch penalty, with no delay slot.
- Flush combined with stall: the flush wins. Flush does not affect the PC.

## Timing
- Reset (asynchronous, while `rst_n` = 0):
  - `pc` = `RESET_PC`
  - `if_id_instr` = `NOP_INSTR`
  - `if_id_pc4` = 0
  - `if_id_valid` = 0
  - `misalign_err` = 0
  - `bad_vaddr` = 0
- Release of reset is sampled at the next rising edge.
- On the first rising edge with `rst_n` = 1 and no stall: IF/ID captures `mem[RESET_PC]` with `valid` = 1, and the PC advances to `RESET_PC + 4`.
- Fetch latency: one cycle from the PC value to the IF/ID output. The memory read is combinational within the cycle.
- All control inputs are sampled at the rising edge. No input is registered internally before use.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock. Pending redirects are discarded.
- `misalign_err` never stays high for two consecutive cycles unless misaligned redirects occur on consecutive cycles.

## Test plan
- Reset, then free-run 4 cycles with memory words 0x20080001, 0x20090002, 0x01095020, 0x00000000:
  - IF/ID shows them in order, with `pc4` = 4, 8, 12, 16 and `valid` = 1.
  - `imem_addr` sequence is 0, 4, 8, 12, 16.
- Assert `stall` for 2 cycles while PC = 8:
  - PC stays 8.
  - IF/ID holds the word from address 4 with `pc4` = 8.
  - On release, the word at 8 is captured.
- `branch_taken` = 1, `branch_target` = 0x40, at PC = 0x10:
  - Next PC = 0x40.
  - IF/ID becomes a bubble (NOP, `valid` = 0).
  - The following cycle, IF/ID holds `mem[0x40]` with `pc4` = 0x44.
  - Repeat with `jump` also asserted (`jump_target` = 0x80): the branch target 0x40 wins.
- Branch with `stall` asserted in the same cycle: PC still goes to the target and IF/ID is a bubble. Separately, `flush` with `stall`: IF/ID becomes a bubble and the PC holds.
- `jump_target` = 0x102:
  - PC = 0x80.
  - `misalign_err` pulses for 1 cycle.
  - `bad_vaddr` = 0x102.
  - IF/ID is a bubble.
- Force PC to 0xFFFF_FFFC via `jump`, then run 1 cycle: PC = 0x0. Pull `rst_n` low between clock edges: all outputs take reset values immediately.
